// File: rtl/id_ex_stage.sv
// Decode / operand-fetch stage and ID/EX register.
// Bypasses same-cycle writeback and bubbles on load-use.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [XLEN-1:0]       if_pc,
  output logic                  id_ready,
  output logic [REG_ADDR_W-1:0] add_rs1,
  output logic [REG_ADDR_W-1:0] add_rs2,
  input  logic [XLEN-1:0]       data_rs1,
  input  logic [XLEN-1:0]       data_rs2,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  flush,
  input  logic                  ex_stall,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_val,
  output logic [XLEN-1:0]       ex_rs2_val,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [6:0]            ex_opcode,
  output logic [2:0]            ex_funct3,
  output logic                  ex_funct7b5,
  output logic                  ex_regwrite,
  output logic                  ex_memread,
  output logic                  ex_memwrite,
  output logic                  ex_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rd;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
    logic                  illegal;
  } id_ex_t;

  id_ex_t ex_d, ex_q, dec;

  logic [6:0]            opc;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]       rs1_val, rs2_val;
  logic [31:0]           imm32;
  logic                  use_rs1, use_rs2;
  logic                  wr_rd, legal;
  logic                  hazard;

  assign opc     = if_instr[6:0];
  assign rs1     = if_instr[15 +: REG_ADDR_W];
  assign rs2     = if_instr[20 +: REG_ADDR_W];
  assign rd      = if_instr[7 +: REG_ADDR_W];
  assign add_rs1 = rs1;
  assign add_rs2 = rs2;

  // Operand select: x0, then same-cycle writeback, then regfile.
  always_comb begin
    rs1_val = data_rs1;
    rs2_val = data_rs2;
    if (rs1 == '0)
      rs1_val = '0;
    else if (wb_regwrite && wb_rd == rs1)
      rs1_val = wb_data;
    if (rs2 == '0)
      rs2_val = '0;
    else if (wb_regwrite && wb_rd == rs2)
      rs2_val = wb_data;
  end

  // Opcode class decode: source use, immediate, rd write.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    wr_rd   = 1'b0;
    legal   = 1'b1;
    imm32   = '0;
    unique case (opc)
      OP_LUI, OP_AUIPC: begin
        wr_rd = 1'b1;
        imm32 = {if_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        wr_rd = 1'b1;
        imm32 = {{11{if_instr[31]}}, if_instr[31],
                 if_instr[19:12], if_instr[20],
                 if_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        wr_rd   = 1'b1;
        use_rs1 = 1'b1;
        imm32   = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{19{if_instr[31]}}, if_instr[31],
                   if_instr[7], if_instr[30:25],
                   if_instr[11:8], 1'b0};
      end
      OP_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm32   = {{20{if_instr[31]}},
                   if_instr[31:25], if_instr[11:7]};
      end
      OP_OP: begin
        wr_rd   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Assemble the decoded bundle for a normal capture.
  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = if_pc;
    dec.rs1_val  = rs1_val;
    dec.rs2_val  = rs2_val;
    dec.imm      = XLEN'($signed(imm32));
    dec.rd       = rd;
    dec.opcode   = opc;
    dec.funct3   = if_instr[14:12];
    dec.funct7b5 = if_instr[30];
    dec.regwrite = legal && wr_rd && rd != '0;
    dec.memread  = legal && opc == OP_LOAD;
    dec.memwrite = legal && opc == OP_STORE;
    dec.illegal  = !legal;
  end

  assign hazard = if_valid && ex_q.valid && ex_q.memread
               && ex_q.rd != '0
               && ((use_rs1 && ex_q.rd == rs1)
                || (use_rs2 && ex_q.rd == rs2));

  assign id_ready = !rst_n || flush || !(ex_stall || hazard);

  // Per-cycle action: flush, stall, hazard, capture, bubble.
  always_comb begin
    ex_d = '0;
    priority case (1'b1)
      flush:    ex_d = '0;
      ex_stall: ex_d = ex_q;
      hazard:   ex_d = '0;
      if_valid: ex_d = dec;
      default:  ex_d = '0;
    endcase
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_val  = ex_q.rs1_val;
  assign ex_rs2_val  = ex_q.rs2_val;
  assign ex_imm      = ex_q.imm;
  assign ex_rd       = ex_q.rd;
  assign ex_opcode   = ex_q.opcode;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7b5 = ex_q.funct7b5;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage.
// Hand-computed expectations checked with immediate asserts.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic [4:0]  add_rs1, add_rs2;
  logic [31:0] data_rs1, data_rs2;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush, ex_stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_regwrite, ex_memread;
  logic        ex_memwrite, ex_illegal;

  int tests = 0;
  int fails = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_ready(id_ready),
    .add_rs1(add_rs1), .add_rs2(add_rs2),
    .data_rs1(data_rs1), .data_rs2(data_rs2),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_data(wb_data),
    .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [31:0] ins,
                       input logic [31:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    data_rs1 = '0; data_rs2 = '0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; ex_stall = 1'b0;
    #2;
    chk("rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_ready", {31'b0, id_ready}, 32'd1);
    tick(); tick();
    rst_n = 1'b1;

    // addi x5,x0,7
    drive(1'b1, 32'h00700293, 32'h100);
    data_rs1 = 32'hDEAD;
    tick();
    chk("addi_valid", {31'b0, ex_valid}, 32'd1);
    chk("addi_rd", {27'b0, ex_rd}, 32'd5);
    chk("addi_imm", ex_imm, 32'd7);
    chk("addi_rs1", ex_rs1_val, 32'd0);
    chk("addi_rw", {31'b0, ex_regwrite}, 32'd1);
    chk("addi_pc", ex_pc, 32'h100);

    // sw x5,-4(x6)
    drive(1'b1, 32'hFE532E23, 32'h104);
    data_rs1 = 32'h100; data_rs2 = 32'hAB;
    #1;
    chk("sw_addr1", {27'b0, add_rs1}, 32'd6);
    chk("sw_addr2", {27'b0, add_rs2}, 32'd5);
    tick();
    chk("sw_imm", ex_imm, 32'hFFFFFFFC);
    chk("sw_rs1", ex_rs1_val, 32'h100);
    chk("sw_rs2", ex_rs2_val, 32'hAB);
    chk("sw_mw", {31'b0, ex_memwrite}, 32'd1);
    chk("sw_rw", {31'b0, ex_regwrite}, 32'd0);

    // add x8,x7,x6 with bypass of x6
    drive(1'b1, 32'h00638433, 32'h108);
    data_rs1 = 32'h11; data_rs2 = 32'h0;
    wb_regwrite = 1'b1; wb_rd = 5'd6; wb_data = 32'h55;
    tick();
    chk("byp_rs2", ex_rs2_val, 32'h55);
    chk("byp_rs1", ex_rs1_val, 32'h11);
    chk("byp_rd", {27'b0, ex_rd}, 32'd8);

    // same with wb_rd = 0: no bypass
    wb_rd = 5'd0;
    tick();
    chk("nobyp_rs2", ex_rs2_val, 32'h0);
    chk("nobyp_rs1", ex_rs1_val, 32'h11);
    wb_regwrite = 1'b0; wb_data = '0;

    // lw x7,0(x6) then add x8,x7,x6
    drive(1'b1, 32'h00032383, 32'h200);
    data_rs1 = 32'h200; data_rs2 = 32'h0;
    tick();
    chk("lw_mr", {31'b0, ex_memread}, 32'd1);
    chk("lw_rd", {27'b0, ex_rd}, 32'd7);
    drive(1'b1, 32'h00638433, 32'h204);
    #1;
    chk("lu_ready0", {31'b0, id_ready}, 32'd0);
    tick();
    chk("lu_bubble", {31'b0, ex_valid}, 32'd0);
    chk("lu_bub_mr", {31'b0, ex_memread}, 32'd0);
    chk("lu_ready1", {31'b0, id_ready}, 32'd1);
    tick();
    chk("lu_add_v", {31'b0, ex_valid}, 32'd1);
    chk("lu_add_pc", ex_pc, 32'h204);
    chk("lu_add_op", {25'b0, ex_opcode}, 32'h33);

    // lw x7 then add x8,x6,x6: no hazard
    drive(1'b1, 32'h00032383, 32'h210);
    tick();
    drive(1'b1, 32'h00630433, 32'h214);
    data_rs1 = 32'h77; data_rs2 = 32'h77;
    #1;
    chk("nolu_ready", {31'b0, id_ready}, 32'd1);
    tick();
    chk("nolu_v", {31'b0, ex_valid}, 32'd1);
    chk("nolu_pc", ex_pc, 32'h214);
    chk("nolu_rs2", ex_rs2_val, 32'h77);

    // rs1==rs2 both bypassed
    wb_regwrite = 1'b1; wb_rd = 5'd6; wb_data = 32'h99;
    tick();
    chk("same_rs1", ex_rs1_val, 32'h99);
    chk("same_rs2", ex_rs2_val, 32'h99);
    wb_regwrite = 1'b0;

    // flush with valid add
    flush = 1'b1;
    #1;
    chk("fl_ready", {31'b0, id_ready}, 32'd1);
    tick();
    chk("fl_valid", {31'b0, ex_valid}, 32'd0);
    chk("fl_rw", {31'b0, ex_regwrite}, 32'd0);
    flush = 1'b0;

    // stall 3 cycles
    drive(1'b1, 32'h00638433, 32'h300);
    tick();
    chk("st_pre_v", {31'b0, ex_valid}, 32'd1);
    ex_stall = 1'b1;
    drive(1'b1, 32'h00700293, 32'h304);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_ready", {31'b0, id_ready}, 32'd0);
      tick();
      chk("st_pc", ex_pc, 32'h300);
      chk("st_rd", {27'b0, ex_rd}, 32'd8);
      chk("st_v", {31'b0, ex_valid}, 32'd1);
    end

    // flush + stall -> bubble
    flush = 1'b1;
    #1;
    chk("fs_ready", {31'b0, id_ready}, 32'd1);
    tick();
    chk("fs_valid", {31'b0, ex_valid}, 32'd0);
    flush = 1'b0; ex_stall = 1'b0;

    // addi x0,x0,1
    drive(1'b1, 32'h00100013, 32'h400);
    tick();
    chk("x0_v", {31'b0, ex_valid}, 32'd1);
    chk("x0_rw", {31'b0, ex_regwrite}, 32'd0);
    chk("x0_imm", ex_imm, 32'd1);

    // illegal opcode
    drive(1'b1, 32'h0000007F, 32'h404);
    tick();
    chk("ill_v", {31'b0, ex_valid}, 32'd1);
    chk("ill_flag", {31'b0, ex_illegal}, 32'd1);
    chk("ill_rw", {31'b0, ex_regwrite}, 32'd0);

    // beq x0,x0,-8
    drive(1'b1, 32'hFE000CE3, 32'h408);
    tick();
    chk("b_imm", ex_imm, 32'hFFFFFFF8);
    chk("b_ill", {31'b0, ex_illegal}, 32'd0);

    // lui x5,0x12345
    drive(1'b1, 32'h123452B7, 32'h40C);
    tick();
    chk("u_imm", ex_imm, 32'h12345000);
    chk("u_rw", {31'b0, ex_regwrite}, 32'd1);

    // async reset during a stall
    drive(1'b1, 32'h00700293, 32'h500);
    tick();
    ex_stall = 1'b1;
    tick();
    chk("ar_pre_v", {31'b0, ex_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, ex_valid}, 32'd0);
    chk("ar_pc", ex_pc, 32'd0);
    chk("ar_ready", {31'b0, id_ready}, 32'd1);
    #1;
    rst_n = 1'b1;
    ex_stall = 1'b0;
    drive(1'b1, 32'h00700293, 32'h600);
    tick();
    chk("ar_post_v", {31'b0, ex_valid}, 32'd1);
    chk("ar_post_pc", ex_pc, 32'h600);
    chk("ar_post_imm", ex_imm, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
